alu_rr_arbiter: RTL

Round-robin front end that shares one registered ALU datapath (`alu_reg`) among `N_REQ` requesters. It accepts operations over per-requester valid/ready handshakes and issues at most one per cycle. A credit scheme covers the ALU stage plus a 2-entry response FIFO, and each result returns to its originating requester in issue order. It sits between the requester ports and the ALU and guarantees that no result is ever dropped under response backpressure.

---
 rtl/alu_arb_pkg.sv | 22 ++
 rtl/alu_reg.sv | 48 ++++
 rtl/alu_rr_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcodes, response-queue sizing and the response entry type for the
// round-robin ALU front end.
package alu_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_GE  = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam int unsigned RSP_DEPTH = 2;

    // Default datapath geometry; the response entry is sized from these.
    localparam int unsigned ARB_WIDTH = 8;
    localparam int unsigned ARB_N_REQ = 4;
    localparam int unsigned ARB_ID_W  = $clog2(ARB_N_REQ);

    typedef struct packed {
        logic [ARB_ID_W-1:0]  id;
        logic [ARB_WIDTH-1:0] result;
    } rsp_entry_t;

endpackage

// File: rtl/alu_reg.sv
// Single-stage registered ALU: result and valid appear one cycle after valid_i.
module alu_reg
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = ARB_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] w_result;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;

    // Shift amounts at or beyond the operand width flush to zero.
    always_comb begin
        w_result = '0;
        case (op_i)
            OP_ADD:  w_result = a_i + b_i;
            OP_GE:   w_result = WIDTH'(a_i >= b_i);
            OP_SHL:  w_result = (32'(a_i) >= WIDTH) ? '0 : (b_i << a_i);
            OP_NOR:  w_result = ~(a_i | b_i);
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_result <= w_result;
            end
        end
    end

    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin, credit-limited front end sharing one registered ALU among
// N_REQ requesters; results return through a 2-entry queue in issue order.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = ARB_WIDTH,
    parameter int unsigned N_REQ = ARB_N_REQ
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_first_i,
    input  logic [N_REQ*WIDTH-1:0] req_second_i,
    input  logic [2*N_REQ-1:0]     req_opcode_i,
    output logic [N_REQ-1:0]       rsp_valid_o,
    input  logic [N_REQ-1:0]       rsp_ready_i,
    output logic [WIDTH-1:0]       rsp_result_o,
    output logic                   idle_o
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);

    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  r_inflight_id;
    rsp_entry_t       r_fifo [RSP_DEPTH];
    logic [CNT_W-1:0] r_count;

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_id;
    logic             w_grant_any;
    logic [ID_W-1:0]  w_head_id;
    logic             w_fifo_ne;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_used;
    logic             w_issue_ok;
    logic             w_issue;
    logic [PTR_W-1:0] w_wr_idx;
    rsp_entry_t       w_push_entry;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [1:0]       w_op;
    logic             w_alu_valid;
    logic [WIDTH-1:0] w_alu_result;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] last, input int unsigned off);
        return ID_W'((32'(last) + off) % N_REQ);
    endfunction

    // First valid requester after the last one granted, wrapping around.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!w_grant_any && req_valid_i[rr_idx(r_last, i)]) begin
                w_grant_any = 1'b1;
                w_grant_id  = rr_idx(r_last, i);
            end
        end
        w_grant = w_grant_any ? (N_REQ'(1) << w_grant_id) : '0;
    end

    // A slot freed by this cycle's pop can be reused by this cycle's issue.
    assign w_head_id  = ID_W'(r_fifo[0].id);
    assign w_fifo_ne  = (r_count != '0);
    assign w_pop      = w_fifo_ne & rsp_ready_i[w_head_id];
    assign w_push     = w_alu_valid;
    assign w_used     = CNT_W'(w_alu_valid) + r_count;
    assign w_issue_ok = (w_used - CNT_W'(w_pop)) < CNT_W'(RSP_DEPTH);
    assign w_issue    = w_grant_any & w_issue_ok & ~rst_i;
    assign w_wr_idx   = PTR_W'(r_count - CNT_W'(w_pop));

    assign w_op_a = req_first_i[w_grant_id*WIDTH +: WIDTH];
    assign w_op_b = req_second_i[w_grant_id*WIDTH +: WIDTH];
    assign w_op   = req_opcode_i[2*w_grant_id +: 2];

    assign w_push_entry = '{id: ARB_ID_W'(r_inflight_id), result: ARB_WIDTH'(w_alu_result)};

    alu_reg #(
        .WIDTH(WIDTH)
    ) u_alu (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (w_issue),
        .a_i      (w_op_a),
        .b_i      (w_op_b),
        .op_i     (w_op),
        .valid_o  (w_alu_valid),
        .result_o (w_alu_result)
    );

    // Head sits in slot 0; a pop shifts the queue down before the push lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last        <= ID_W'(N_REQ - 1);
            r_inflight_id <= '0;
            r_count       <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_last        <= w_grant_id;
                r_inflight_id <= w_grant_id;
            end
            if (w_pop) begin
                for (int unsigned i = 0; i + 1 < RSP_DEPTH; i++) begin
                    r_fifo[i] <= r_fifo[i+1];
                end
            end
            if (w_push) begin
                r_fifo[w_wr_idx] <= w_push_entry;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign req_ready_o  = w_issue ? w_grant : '0;
    assign rsp_valid_o  = w_fifo_ne ? (N_REQ'(1) << w_head_id) : '0;
    assign rsp_result_o = w_fifo_ne ? WIDTH'(r_fifo[0].result) : '0;
    assign idle_o       = ~w_alu_valid & ~w_fifo_ne;

endmodule
